uart_echo_fifo: RTL and testbench
=================================

# uart_echo_fifo

Buffered, mode-selectable UART echo engine placed between the `uart` block's receive stream (`output_axis_*`) and its transmit stream (`input_axis_*`). It decouples receive from transmit with a parametrised FIFO, so bytes arriving while the transmitter is busy are queued instead of stalling the receiver. Bytes can be optionally transformed on the way through: uppercase conversion, CR→CR LF expansion, or discard. Overflow is reported, and optional statistics counters are available.

## Interface
- `DATA_WIDTH`, default 8: stream byte width; must be ≥ 8.
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥ 2.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `input_axis_tdata` in DATA_WIDTH: byte from the UART receiver.
- `input_axis_tvalid` in 1: receive byte valid.
- `input_axis_tready` out 1: accept; 1 whenever out of reset.
- `output_axis_tdata` out DATA_WIDTH: byte to the UART transmitter.
- `output_axis_tvalid` out 1: transmit byte valid.
- `output_axis_tready` in 1: transmitter accept.
- `mode` in 2: 00 echo, 01 uppercase, 10 sink, 11 CR→CR LF.
- `clr` in 1: single-cycle pulse; clears `overflow` and the statistics counters.
- `fifo_count` out $clog2(DEPTH)+1: entries held in memory (excludes the output register).
- `overflow` out 1: sticky flag; a byte was dropped because the FIFO was full.
- `rx_count` out 32: accepted-byte counter (wraps).
- `drop_count` out 16: dropped-byte counter (saturates at 0xFFFF).

## Operation
- Every cycle in which `input_axis_tvalid` is 1 is a handshake. The UART has no backpressure, so this block never stalls it.
- `mode` is sampled on each input handshake and applies only to that byte.
- Transform at write time:
  - Mode 01: a byte in 0x61..0x7A has 0x20 subtracted. All other values, including bits above bit 7, pass unchanged.
  - Mode 10: the byte is accepted and counted in `rx_count`, but not written to the FIFO.
- FIFO entry is DATA_WIDTH+1 bits. The extra bit is the `lf` flag: set when mode is 11 and the byte equals 0x0D.
- Full (`fifo_count == DEPTH`) with a non-sink handshake: the byte is discarded, `overflow` is set, and `drop_count` increments.
- A write and a read in the same cycle leave `fifo_count` unchanged. A write while full that coincides with a read is accepted, not dropped.
- Output FSM, one `output_axis` register stage:
  - IDLE: `tvalid` 0. If the FIFO is non-empty, pop the head into the register and go to DATA.
  - DATA: `tvalid` 1. On handshake:
    - If the held `lf` flag is set, load 0x0A and go to LF.
    - Else, if the FIFO is non-empty, pop the next entry and stay in DATA (back-to-back).
    - Else go to IDLE.
  - LF: `tvalid` 1, `tdata` 0x0A. On handshake, pop the next entry and go to DATA if the FIFO is non-empty; otherwise go to IDLE.
- While `tvalid` is 1 and `tready` is 0, `tdata` is held stable.
- `clr` coinciding with an overflow event: `clr` wins, so the flag and counters read 0 afterwards.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are derived from `fifo_count`.

## Timing
- Reset values (asserted immediately, asynchronously):
  - `input_axis_tready` 0, `output_axis_tvalid` 0, `output_axis_tdata` 0.
  - `fifo_count` 0, `overflow` 0, `rx_count` 0, `drop_count` 0.
  - FSM in IDLE.
- `rst_n` asserted mid-operation discards all queued bytes, including a byte presented but not yet accepted.
- Latency: an input handshake at edge k writes memory; the output register loads at edge k+1, so `output_axis_tvalid` is 1 after edge k+1 (2 cycles input-to-output with an idle output).
- Sustained throughput: one byte per cycle. The LF insertion costs one extra output beat.

## Configuration
- `UART_ECHO_STATS_EN`:
  - Defined: `rx_count` and `drop_count` are implemented as described.
  - Undefined: both ports are tied to 0 and no counter flops exist.
- `overflow` and `fifo_count` are present in both builds.

## Structure
- Package `uart_echo_pkg` holds:
  - mode encodings (ECHO, UPPER, SINK, CRLF);
  - output FSM state enum (IDLE, DATA, LF);
  - ASCII constants 0x0D, 0x0A, 0x61, 0x7A, 0x20.
- One sub-module, `uart_echo_fifo_mem`: DEPTH × (DATA_WIDTH+1) storage with read/write pointers and `fifo_count`.
- Transform logic, drop/overflow handling, output FSM and statistics stay in the top module.

## Test plan
- Echo: mode 00, send 0x41 then 0x62 with `tready`=1 → output 0x41, 0x62; `tvalid` is 1 two cycles after each input.
- Uppercase: mode 01, send 0x61, 0x5A, 0x7B → output 0x41, 0x5A, 0x7B.
- CR LF: mode 11, send 0x0D, 0x31, with `tready` low for 5 cycles while 0x0A is presented → output 0x0D, 0x0A, 0x31, with 0x0A stable throughout the stall.
- Overflow: DEPTH=16, `tready`=0, send 20 bytes:
  - Expect `fifo_count`=16, `overflow`=1; with stats enabled, `drop_count`=3 and `rx_count`=20.
  - Then set `tready`=1 → 17 bytes out in order; pulse `clr` → `overflow`=0.
- Sink: mode 10, send 5 bytes → no `tvalid`, `fifo_count`=0, `rx_count`=5.
- Reset mid-stream: 8 bytes queued, drop `rst_n` → all outputs read 0 in the same cycle; after release, no stale output appears.

Source files
------------

// File: rtl/uart_echo_fifo_pkg.sv
// rtl/uart_echo_fifo_pkg.sv - shared types and ASCII constants for the UART echo FIFO
//
// Purpose: mode encodings, output FSM state enum and the ASCII byte values
// used by the transform and line-feed insertion logic.
// Ports: none (package).

package uart_echo_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO  = 2'b00,
    MODE_UPPER = 2'b01,
    MODE_SINK  = 2'b10,
    MODE_CRLF  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_LF   = 2'b10
  } out_state_e;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

endpackage

// File: rtl/uart_echo_fifo_mem.sv
// rtl/uart_echo_fifo_mem.sv - DEPTH x WIDTH circular buffer with occupancy count
//
// Purpose: storage for the echo FIFO. Read data is the head entry, available
// combinationally; a read pops it.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en_i, wr_data_i push an entry (honoured when not full, or when full with a pop)
//   rd_en_i            pop the head entry (ignored when empty)
//   rd_data_o          head entry
//   count_o            entries held
//   full_o, empty_o    occupancy flags derived from count_o

module uart_echo_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             rd_ok, wr_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - buffered, mode-selectable UART echo engine
//
// Purpose: accepts every receive byte, transforms it per mode (echo, uppercase,
// sink, CR->CR LF), queues it and replays it through a one-stage output
// register. Drops when full are flagged in a sticky overflow bit.
// Build option: UART_ECHO_STATS_EN implements rx_count/drop_count; otherwise
// both ports read 0.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   input_axis_tdata/tvalid/tready  receive stream (never back-pressured)
//   output_axis_tdata/tvalid/tready transmit stream
//   mode                            00 echo, 01 upper, 10 sink, 11 CR LF
//   clr                             clears overflow and statistics
//   fifo_count                      entries in memory (excludes output register)
//   overflow                        sticky drop flag
//   rx_count, drop_count            accepted / dropped byte counters

module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   input_axis_tdata,
  input  logic                    input_axis_tvalid,
  output logic                    input_axis_tready,
  output logic [DATA_WIDTH-1:0]   output_axis_tdata,
  output logic                    output_axis_tvalid,
  input  logic                    output_axis_tready,
  input  logic [1:0]              mode,
  input  logic                    clr,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic [31:0]             rx_count,
  output logic [15:0]             drop_count
);

  logic                  rdy_q;
  logic                  in_hs;
  logic                  wr_req, wr_en, drop;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_lf;
  logic [DATA_WIDTH:0]   rd_data;
  logic                  fifo_full, fifo_empty, pop;

  out_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  lf_q, lf_d;
  logic                  overflow_q, overflow_d;

  // Ready rises the cycle after reset release and stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  assign input_axis_tready = rdy_q;
  assign in_hs             = input_axis_tvalid && rdy_q;

  // Write-time transform; the whole word is compared so wide values with upper
  // bits set are never treated as lowercase letters or CR.
  always_comb begin
    wr_data = input_axis_tdata;
    wr_lf   = 1'b0;
    case (mode_e'(mode))
      MODE_UPPER: begin
        if (input_axis_tdata >= DATA_WIDTH'(ASCII_LC_A) &&
            input_axis_tdata <= DATA_WIDTH'(ASCII_LC_Z))
          wr_data = input_axis_tdata - DATA_WIDTH'(ASCII_CASE_OFS);
      end
      MODE_CRLF: wr_lf = (input_axis_tdata == DATA_WIDTH'(ASCII_CR));
      default:   ;
    endcase
  end

  assign wr_req = in_hs && (mode_e'(mode) != MODE_SINK);
  assign wr_en  = wr_req && (!fifo_full || pop);
  assign drop   = wr_req && fifo_full && !pop;

  uart_echo_fifo_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i ({wr_lf, wr_data}),
    .rd_en_i   (pop),
    .rd_data_o (rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Output FSM: one register stage; the LF state inserts 0x0A after a flagged CR.
  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    lf_d    = lf_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop             = 1'b1;
          {lf_d, tdata_d} = rd_data;
          state_d         = ST_DATA;
        end
      end
      ST_DATA: begin
        if (output_axis_tready) begin
          if (lf_q) begin
            tdata_d = DATA_WIDTH'(ASCII_LF);
            lf_d    = 1'b0;
            state_d = ST_LF;
          end else if (!fifo_empty) begin
            pop             = 1'b1;
            {lf_d, tdata_d} = rd_data;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_LF: begin
        if (output_axis_tready) begin
          if (!fifo_empty) begin
            pop             = 1'b1;
            {lf_d, tdata_d} = rd_data;
            state_d         = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tdata_q <= '0;
      lf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tdata_q <= tdata_d;
      lf_q    <= lf_d;
    end
  end

  assign output_axis_tvalid = (state_q != ST_IDLE);
  assign output_axis_tdata  = tdata_q;

  // clr takes priority over a simultaneous drop.
  always_comb begin
    overflow_d = overflow_q;
    if (clr)       overflow_d = 1'b0;
    else if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef UART_ECHO_STATS_EN
  logic [31:0] rx_count_q, rx_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    rx_count_d   = rx_count_q;
    drop_count_d = drop_count_q;
    if (clr) begin
      rx_count_d   = '0;
      drop_count_d = '0;
    end else begin
      if (in_hs) rx_count_d = rx_count_q + 32'd1;
      if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      rx_count_q   <= rx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign rx_count   = rx_count_q;
  assign drop_count = drop_count_q;
`else
  assign rx_count   = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb/tb_uart_echo_fifo.sv - scoreboard bench for uart_echo_fifo

module tb_uart_echo_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [DW-1:0]          input_axis_tdata;
  logic                   input_axis_tvalid;
  logic                   input_axis_tready;
  logic [DW-1:0]          output_axis_tdata;
  logic                   output_axis_tvalid;
  logic                   output_axis_tready;
  logic [1:0]             mode;
  logic                   clr;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic [31:0]            rx_count;
  logic [15:0]            drop_count;

  uart_echo_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .mode               (mode),
    .clr                (clr),
    .fifo_count         (fifo_count),
    .overflow           (overflow),
    .rx_count           (rx_count),
    .drop_count         (drop_count)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [7:0]    exp_q[$];
  int            rx_exp = 0;
  int            drop_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef UART_ECHO_STATS_EN
    check({tag, "_rx_count"}, rx_count, rx_exp);
    check({tag, "_drop_count"}, {16'h0, drop_count}, drop_exp);
`else
    check({tag, "_rx_count"}, rx_count, 32'h0);
    check({tag, "_drop_count"}, {16'h0, drop_count}, 32'h0);
`endif
  endtask

  // Called at posedge+1; returns at the next posedge+1 after the handshake edge.
  task automatic send(input logic [7:0] b, input logic [1:0] m);
    input_axis_tdata  = b;
    mode              = m;
    input_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    input_axis_tvalid = 1'b0;
    rx_exp++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 300) begin
      tick();
      cnt++;
    end
    check({tag, "_drained_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: compares every output handshake against the scoreboard and checks
  // that data holds while the sink stalls.
  initial begin
    logic       stall_prev;
    logic [7:0] data_prev;
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && output_axis_tvalid)
          check("stall_hold", output_axis_tdata, data_prev);
        if (output_axis_tvalid && output_axis_tready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out: got 0x%0h, expected no output at %0t", output_axis_tdata, $time);
          end else begin
            check("out_data", output_axis_tdata, exp_q.pop_front());
          end
        end
        stall_prev = output_axis_tvalid && !output_axis_tready;
        data_prev  = output_axis_tdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst_n              = 1'b0;
    input_axis_tdata   = '0;
    input_axis_tvalid  = 1'b0;
    output_axis_tready = 1'b0;
    mode               = 2'b00;
    clr                = 1'b0;
    #7;
    check("rst_in_tready", input_axis_tready, 0);
    check("rst_out_tvalid", output_axis_tvalid, 0);
    check("rst_out_tdata", output_axis_tdata, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check_stats("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();
    check("in_tready_up", input_axis_tready, 1);

    // Echo with latency checks
    output_axis_tready = 1'b1;
    exp_q.push_back(8'h41);
    send(8'h41, 2'b00);
    check("echo_lat_k", output_axis_tvalid, 0);
    tick();
    check("echo_lat_k1", output_axis_tvalid, 1);
    check("echo_data0", output_axis_tdata, 8'h41);
    exp_q.push_back(8'h62);
    send(8'h62, 2'b00);
    check("echo_lat2_k", output_axis_tvalid, 0);
    tick();
    check("echo_lat2_k1", output_axis_tvalid, 1);
    check("echo_data1", output_axis_tdata, 8'h62);
    drain("echo");

    // Uppercase
    exp_q.push_back(8'h41); exp_q.push_back(8'h5A); exp_q.push_back(8'h7B);
    send(8'h61, 2'b01);
    send(8'h5A, 2'b01);
    send(8'h7B, 2'b01);
    drain("upper");

    // CR -> CR LF with a 5-cycle stall on the inserted LF
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); exp_q.push_back(8'h31);
    send(8'h0D, 2'b11);
    send(8'h31, 2'b11);
    cnt = 0;
    while (!(output_axis_tvalid && output_axis_tdata == 8'h0A) && cnt < 20) begin
      tick();
      cnt++;
    end
    output_axis_tready = 1'b0;
    check("crlf_lf_seen", output_axis_tdata, 8'h0A);
    repeat (5) tick();
    check("crlf_lf_held_valid", output_axis_tvalid, 1);
    check("crlf_lf_held_data", output_axis_tdata, 8'h0A);
    output_axis_tready = 1'b1;
    drain("crlf");

    // Overflow: 20 bytes with the transmitter stalled
    output_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < 17) exp_q.push_back(8'h30 + 8'(i));
      send(8'h30 + 8'(i), 2'b00);
    end
    drop_exp += 3;
    check("ovf_fifo_count", fifo_count, 16);
    check("ovf_flag", overflow, 1);
    check_stats("ovf");
    output_axis_tready = 1'b1;
    drain("ovf");
    tick();
    check("ovf_fifo_empty", fifo_count, 0);
    check("ovf_flag_sticky", overflow, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    rx_exp   = 0;
    drop_exp = 0;
    check("clr_overflow", overflow, 0);
    check_stats("clr");

    // Sink
    for (int i = 0; i < 5; i++) send(8'h70 + 8'(i), 2'b10);
    repeat (3) tick();
    check("sink_tvalid", output_axis_tvalid, 0);
    check("sink_fifo_count", fifo_count, 0);
    check_stats("sink");

    // Reset mid-stream
    output_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 2'b00);
    tick();
    check("pre_rst_fifo_count", fifo_count, 7);
    check("pre_rst_tvalid", output_axis_tvalid, 1);
    input_axis_tdata  = 8'h55;
    input_axis_tvalid = 1'b1;
    #2 rst_n = 1'b0;
    rx_exp   = 0;
    drop_exp = 0;
    #1;
    check("midrst_in_tready", input_axis_tready, 0);
    check("midrst_out_tvalid", output_axis_tvalid, 0);
    check("midrst_out_tdata", output_axis_tdata, 0);
    check("midrst_fifo_count", fifo_count, 0);
    check("midrst_overflow", overflow, 0);
    check_stats("midrst");
    input_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    output_axis_tready = 1'b1;
    repeat (10) tick();
    check("postrst_tvalid", output_axis_tvalid, 0);
    check("postrst_fifo_count", fifo_count, 0);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
